// File: rtl/gpu_host_csr.sv
// gpu_host_csr: AXI-lite host CSR slave driving per-SM launch pulses, busy tracking and a maskable completion irq.
module gpu_host_csr #(
  parameter int          NUM_SMS    = 4,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h4750_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_awvalid,
  output logic                  host_awready,
  input  logic [ADDR_WIDTH-1:0] host_awaddr,
  input  logic                  host_wvalid,
  output logic                  host_wready,
  input  logic [31:0]           host_wdata,
  output logic                  host_bvalid,
  input  logic                  host_bready,
  output logic [1:0]            host_bresp,
  input  logic                  host_arvalid,
  output logic                  host_arready,
  input  logic [ADDR_WIDTH-1:0] host_araddr,
  output logic                  host_rvalid,
  input  logic                  host_rready,
  output logic [31:0]           host_rdata,
  output logic [1:0]            host_rresp,
  output logic [NUM_SMS-1:0]    sm_launch,
  input  logic [NUM_SMS-1:0]    sm_done,
  output logic                  irq
);
  logic                  aw_held, w_held, enable;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q, scratch, launch_count, launch_pop, rd_data;
  logic [NUM_SMS-1:0]    busy, irq_status, irq_en, launch_ok, w1c;
  logic                  aw_full, w_full, commit, wmap, wsel, rmap;
  logic [ADDR_WIDTH-1:0] wa;
  logic [31:0]           wd;
  logic [2:0]            woff;
  assign host_awready = !aw_held;
  assign host_wready  = !w_held;
  assign host_arready = !host_rvalid;
  // A beat arriving this cycle counts as held, so same-cycle AW+W commits immediately.
  assign aw_full = aw_held | host_awvalid;
  assign w_full  = w_held | host_wvalid;
  assign commit  = aw_full & w_full & !host_bvalid;
  assign wa      = aw_held ? aw_addr_q : host_awaddr;
  assign wd      = w_held ? w_data_q : host_wdata;
  assign wmap    = wa[ADDR_WIDTH-1:5] == '0;
  assign wsel    = commit & wmap;
  assign woff    = wa[4:2];
  assign launch_ok = (wsel && woff == 3'd2) ? wd[NUM_SMS-1:0] & ~busy & {NUM_SMS{enable}} : '0;
  assign w1c       = (wsel && woff == 3'd4) ? wd[NUM_SMS-1:0] : '0;
  assign rmap      = host_araddr[ADDR_WIDTH-1:5] == '0;
  always_comb begin
    launch_pop = '0;
    for (int i = 0; i < NUM_SMS; i++) launch_pop = launch_pop + 32'(launch_ok[i]);
  end
  always_comb begin
    rd_data = '0;
    case (host_araddr[4:2])
      3'd0: rd_data = ID_VALUE;
      3'd1: rd_data = {31'b0, enable};
      3'd3: rd_data = 32'(busy);
      3'd4: rd_data = 32'(irq_status);
      3'd5: rd_data = 32'(irq_en);
      3'd6: rd_data = scratch;
      3'd7: rd_data = launch_count;
      default: rd_data = '0;
    endcase
    rd_data = rmap ? rd_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      host_bvalid  <= 1'b0;
      host_bresp   <= 2'b00;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
      host_rresp   <= 2'b00;
      enable       <= 1'b0;
      busy         <= '0;
      irq_status   <= '0;
      irq_en       <= '0;
      scratch      <= '0;
      launch_count <= '0;
      sm_launch    <= '0;
      irq          <= 1'b0;
    end else begin
      aw_held <= commit ? 1'b0 : aw_full;
      w_held  <= commit ? 1'b0 : w_full;
      if (host_awvalid && !aw_held) aw_addr_q <= host_awaddr;
      if (host_wvalid && !w_held) w_data_q <= host_wdata;
      host_bvalid <= commit | (host_bvalid & !host_bready);
      if (commit) host_bresp <= wmap ? 2'b00 : 2'b10;
      if (host_arvalid && !host_rvalid) begin
        host_rvalid <= 1'b1;
        host_rdata  <= rd_data;
        host_rresp  <= rmap ? 2'b00 : 2'b10;
      end else if (host_rready) host_rvalid <= 1'b0;
      if (wsel && woff == 3'd1) enable <= wd[0];
      if (wsel && woff == 3'd5) irq_en <= wd[NUM_SMS-1:0];
      if (wsel && woff == 3'd6) scratch <= wd;
      // Launch checks pre-update busy, so a same-cycle done on a busy SM rejects the launch.
      busy         <= (busy & ~sm_done) | launch_ok;
      irq_status   <= (irq_status & ~w1c) | sm_done;
      launch_count <= launch_count + launch_pop;
      sm_launch    <= launch_ok;
      irq          <= enable & |(irq_status & irq_en);
    end
  end
endmodule

// File: tb/tb_gpu_host_csr.sv
// tb_gpu_host_csr: directed self-checking bench for gpu_host_csr.
module tb_gpu_host_csr;
  logic        clk = 0, rst_n = 0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [11:0] awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [1:0]  bresp, rresp;
  logic [3:0]  sm_launch, sm_done = 0;
  logic [3:0]  pulse_or = 0;
  int          pulse_cnt = 0, checks = 0, failures = 0;
  logic [1:0]  resp;
  logic [31:0] data;
  int          lat;

  gpu_host_csr dut (
    .clk(clk), .rst_n(rst_n),
    .host_awvalid(awvalid), .host_awready(awready), .host_awaddr(awaddr),
    .host_wvalid(wvalid), .host_wready(wready), .host_wdata(wdata),
    .host_bvalid(bvalid), .host_bready(bready), .host_bresp(bresp),
    .host_arvalid(arvalid), .host_arready(arready), .host_araddr(araddr),
    .host_rvalid(rvalid), .host_rready(rready), .host_rdata(rdata), .host_rresp(rresp),
    .sm_launch(sm_launch), .sm_done(sm_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sm_launch != 0) begin
    pulse_or  = pulse_or | sm_launch;
    pulse_cnt = pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, output logic [1:0] r, output int l);
    logic ga, gw;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      ga = awready; gw = wready;
      tick();
      if (ga) awvalid = 0;
      if (gw) wvalid = 0;
    end
    for (l = 0; l < 20 && !bvalid; l++) tick();
    r = bresp;
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required=1", a, bvalid);
    end
    tick();
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1;
    tick();
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rd_latency addr=%h rvalid=%b required=1", a, rvalid);
    end
    d = rdata; r = rresp;
    tick();
  endtask

  task automatic wr_with_done(input logic [11:0] a, input logic [31:0] d, input logic [3:0] done);
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1; sm_done = done;
    tick();
    awvalid = 0; wvalid = 0; sm_done = 0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq, sm_launch} !== {3'b111, 3'b000, 4'h0}) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=%b", {awready, wready, arready, bvalid, rvalid, irq, sm_launch}, 10'b1110000000);
    end
    @(posedge clk); #1; rst_n = 1; tick();
    rd(12'h000, data, resp);
    checks++;
    if (data !== 32'h4750_0001 || resp !== 2'b00) begin
      failures++;
      $display("FAIL read_id got=%h/%b required=47500001/00", data, resp);
    end
    rd(12'h00C, data, resp);
    checks++;
    if (data !== 32'h0 || resp !== 2'b00) begin
      failures++;
      $display("FAIL read_busy_reset got=%h/%b required=0/00", data, resp);
    end
  endtask

  task automatic test_launch();
    wr(12'h004, 32'h1, resp, lat);
    pulse_or = 0; pulse_cnt = 0;
    wr(12'h008, 32'hF, resp, lat);
    tick();
    checks++;
    if (pulse_or !== 4'hF || pulse_cnt !== 1) begin
      failures++;
      $display("FAIL launch_pulse got=%h x%0d required=f x1", pulse_or, pulse_cnt);
    end
    rd(12'h00C, data, resp);
    checks++;
    if (data !== 32'hF) begin failures++; $display("FAIL busy_after_launch got=%h required=f", data); end
    rd(12'h01C, data, resp);
    checks++;
    if (data !== 32'd4) begin failures++; $display("FAIL launch_count got=%0d required=4", data); end
    pulse_or = 0; pulse_cnt = 0;
    wr(12'h008, 32'h3, resp, lat);
    tick();
    checks++;
    if (pulse_cnt !== 0 || resp !== 2'b00) begin
      failures++;
      $display("FAIL launch_busy_drop got=%0d pulses resp=%b required=0 pulses resp=00", pulse_cnt, resp);
    end
    rd(12'h01C, data, resp);
    checks++;
    if (data !== 32'd4) begin failures++; $display("FAIL launch_count_stays got=%0d required=4", data); end
  endtask

  task automatic test_irq();
    wr(12'h014, 32'h5, resp, lat);
    sm_done = 4'h6; tick(); sm_done = 0; tick(); tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b required=1", irq); end
    rd(12'h00C, data, resp);
    checks++;
    if (data !== 32'h9) begin failures++; $display("FAIL busy_after_done got=%h required=9", data); end
    rd(12'h010, data, resp);
    checks++;
    if (data !== 32'h6) begin failures++; $display("FAIL irq_status got=%h required=6", data); end
    wr(12'h010, 32'h4, resp, lat);
    tick();
    rd(12'h010, data, resp);
    checks++;
    if (data !== 32'h2 || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_w1c got=%h irq=%b required=2 irq=0", data, irq);
    end
  endtask

  task automatic test_back_to_back();
    bready = 0;
    wdata = 32'h1234; awaddr = 12'h018; wvalid = 1;
    tick(); wvalid = 0;
    checks++;
    if (wready !== 1'b0) begin failures++; $display("FAIL w_held_wready got=%b required=0", wready); end
    tick(); tick();
    checks++;
    if (bvalid !== 1'b0) begin failures++; $display("FAIL early_commit bvalid=%b required=0", bvalid); end
    awvalid = 1;
    tick(); awvalid = 0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL b_after_aw got=%b/%b required=1/00", bvalid, bresp);
    end
    awvalid = 1;
    tick(); awvalid = 0;
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin
      failures++;
      $display("FAIL b_hold_aw_held bvalid=%b awready=%b required=1/0", bvalid, awready);
    end
    bready = 1;
    tick();
    checks++;
    if (bvalid !== 1'b0) begin failures++; $display("FAIL b_release got=%b required=0", bvalid); end
    wdata = 32'h5678; wvalid = 1;
    tick(); wvalid = 0;
    checks++;
    if (bvalid !== 1'b1) begin failures++; $display("FAIL second_commit bvalid=%b required=1", bvalid); end
    tick();
    rd(12'h018, data, resp);
    checks++;
    if (data !== 32'h5678) begin failures++; $display("FAIL scratch_b2b got=%h required=5678", data); end
  endtask

  task automatic test_unmapped();
    wr(12'h018, 32'hDEADBEEF, resp, lat);
    checks++;
    if (resp !== 2'b00 || lat !== 0) begin
      failures++;
      $display("FAIL scratch_write resp=%b lat=%0d required=00 lat=0", resp, lat);
    end
    wr(12'h040, 32'h1111_1111, resp, lat);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL unmapped_bresp got=%b required=10", resp); end
    rd(12'h040, data, resp);
    checks++;
    if (resp !== 2'b10 || data !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_read got=%h/%b required=0/10", data, resp);
    end
    rd(12'h018, data, resp);
    checks++;
    if (data !== 32'hDEADBEEF) begin failures++; $display("FAIL scratch_read got=%h required=deadbeef", data); end
  endtask

  task automatic test_races();
    pulse_or = 0; pulse_cnt = 0;
    wr_with_done(12'h008, 32'h1, 4'h1);
    tick();
    rd(12'h00C, data, resp);
    checks++;
    if (data !== 32'h8 || pulse_cnt !== 0) begin
      failures++;
      $display("FAIL done_launch_race busy=%h pulses=%0d required=8 pulses=0", data, pulse_cnt);
    end
    wr(12'h010, 32'hF, resp, lat);
    wr_with_done(12'h010, 32'h2, 4'h2);
    tick();
    rd(12'h010, data, resp);
    checks++;
    if (data !== 32'h2) begin failures++; $display("FAIL w1c_set_race got=%h required=2", data); end
  endtask

  task automatic test_reset_mid_b();
    bready = 0;
    awaddr = 12'h018; wdata = 32'hAAAA; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b1) begin failures++; $display("FAIL mid_b_setup bvalid=%b required=1", bvalid); end
    #2 rst_n = 0; #1;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset bvalid=%b awready=%b required=0/1", bvalid, awready);
    end
    bready = 1;
    tick(); rst_n = 1; tick();
    rd(12'h018, data, resp);
    checks++;
    if (data !== 32'h0) begin failures++; $display("FAIL scratch_after_reset got=%h required=0", data); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_irq();
    test_back_to_back();
    test_unmapped();
    test_races();
    test_reset_mid_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
